// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI slave core: burst encodings, read AG state
// encoding, response codes and the beat-size clamp.
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } ag_state_e;

  // Beats wider than the data bus are narrowed to the full bus width.
  function automatic logic [2:0] clamp_size(input logic [2:0] size,
                                            input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_burst_addr_calc.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Illegal WRAP lengths and the reserved burst type fall back to INCR.
module axi_burst_addr_calc
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_size;
  logic [ADDR_W-1:0] wrap_lo;
  logic              wrap_ok;

  always_comb begin
    bytes     = ADDR_W'(1) << size;
    // Aligning first makes an unaligned start land on the next beat boundary.
    incr_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    wrap_size = (ADDR_W'(len) + ADDR_W'(1)) << size;
    wrap_lo   = start_addr & ~(wrap_size - ADDR_W'(1));
    wrap_ok   = (burst == BURST_WRAP) &&
                ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (wrap_ok && (incr_addr == wrap_lo + wrap_size)) begin
      next_addr = wrap_lo;
    end
  end

endmodule

// File: rtl/axi_read_addr_gen.sv
// AXI slave read address generator: accepts one AR burst, fetches each beat
// from a one-cycle-latency memory and holds it until the R handshake.
module axi_read_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd_En,
  input  logic [DATA_W-1:0] Mem_Rd_Data,
  output logic [ID_W-1:0]   R_ID_OUT,
  output logic              Valid_Data_R,
  output logic [DATA_W-1:0] Read_Data,
  output logic              RLAST,
  input  logic              Read_Ready,
  output ag_state_e         state_dbg
);

  // Handshakes: AR transfers when ARVALID && ARREADY at a rising edge; a beat
  // transfers when Valid_Data_R && Read_Ready. Valid is never withdrawn and
  // the beat (data, ID, last) is held unchanged until it transfers.

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

  ag_state_e         state, state_nxt;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt;
  logic [DATA_W-1:0] data_q;
  logic              first_q;
  logic [ADDR_W-1:0] next_addr;

  axi_burst_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
    .addr       (addr_q),
    .size       (size_q),
    .len        (len_q),
    .burst      (burst_q),
    .start_addr (start_q),
    .next_addr  (next_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ARVALID) state_nxt = FETCH;
      FETCH:   state_nxt = PRESENT;
      PRESENT: if (Read_Ready) state_nxt = RLAST ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ARREADY      = 1'b0;
    Mem_Rd_En    = 1'b0;
    Mem_Addr     = '0;
    Valid_Data_R = 1'b0;
    RLAST        = 1'b0;
    Read_Data    = '0;
    case (state)
      IDLE:  ARREADY = !reset;
      FETCH: begin
        Mem_Rd_En = 1'b1;
        Mem_Addr  = addr_q;
      end
      PRESENT: begin
        Valid_Data_R = 1'b1;
        RLAST        = (beat_cnt == len_q);
        // Memory output is only trusted in the cycle right after the fetch.
        Read_Data    = first_q ? Mem_Rd_Data : data_q;
      end
      default: ;
    endcase
  end

  assign R_ID_OUT  = id_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q     <= '0;
      addr_q   <= '0;
      start_q  <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      data_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      first_q <= (state == FETCH);
      if (state == IDLE && ARVALID) begin
        id_q     <= ARID;
        addr_q   <= ARADDR;
        start_q  <= ARADDR;
        len_q    <= ARLEN;
        size_q   <= clamp_size(ARSIZE, MAX_SIZE);
        burst_q  <= ARBURST;
        beat_cnt <= '0;
      end
      if (state == PRESENT && first_q) data_q <= Mem_Rd_Data;
      if (state == PRESENT && Read_Ready && !RLAST) begin
        beat_cnt <= beat_cnt + 8'd1;
        addr_q   <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_addr_gen.sv
// Directed bench for axi_read_addr_gen with a one-cycle-latency memory model.
module tb_axi_read_addr_gen;
  import axi_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd_En;
  logic [31:0] Mem_Rd_Data;
  logic [5:0]  R_ID_OUT;
  logic        Valid_Data_R;
  logic [31:0] Read_Data;
  logic        RLAST;
  logic        Read_Ready;
  ag_state_e   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit mem_scramble;

  // Observations collected by the burst driver
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [5:0]  obs_id[$];
  logic        obs_last[$];
  logic [31:0] hold_data[$];
  logic        hold_valid[$];
  logic        hold_last[$];
  logic        hold_rden[$];
  int          busy_cycles;
  int          ar_wait;
  logic        ar_after;
  bit          timed_out;

  always #5 clk = ~clk;

  axi_read_addr_gen #(.ADDR_W(32), .DATA_W(32), .ID_W(6)) dut (
    .clk(clk), .reset(reset),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .Mem_Addr(Mem_Addr), .Mem_Rd_En(Mem_Rd_En), .Mem_Rd_Data(Mem_Rd_Data),
    .R_ID_OUT(R_ID_OUT), .Valid_Data_R(Valid_Data_R), .Read_Data(Read_Data),
    .RLAST(RLAST), .Read_Ready(Read_Ready), .state_dbg(state_dbg)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_scramble)   Mem_Rd_Data <= $urandom;
    else if (Mem_Rd_En) Mem_Rd_Data <= mem_word(Mem_Addr);
  end

  task automatic run_burst(input logic [5:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int hold_beat,
                           input int hold_len);
    int  beat;
    int  held;
    bit  done;
    obs_addr.delete(); obs_data.delete(); obs_id.delete(); obs_last.delete();
    hold_data.delete(); hold_valid.delete(); hold_last.delete(); hold_rden.delete();
    busy_cycles = 0; ar_wait = 0; timed_out = 0;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1; Read_Ready = 1'b1;
    while (!ARREADY && ar_wait < 20) begin
      @(negedge clk);
      ar_wait++;
    end
    @(negedge clk);
    ARVALID = 1'b0;
    beat = 0; held = 0; done = 0;
    while (!done && busy_cycles < 2000) begin
      busy_cycles++;
      if (Mem_Rd_En) begin
        obs_addr.push_back(Mem_Addr);
        if (beat == hold_beat) Read_Ready = 1'b0;
      end
      if (Valid_Data_R) begin
        if (held == 0) begin
          obs_data.push_back(Read_Data);
          obs_id.push_back(R_ID_OUT);
          obs_last.push_back(RLAST);
        end
        if (!Read_Ready) begin
          hold_data.push_back(Read_Data);
          hold_valid.push_back(Valid_Data_R);
          hold_last.push_back(RLAST);
          hold_rden.push_back(Mem_Rd_En);
          mem_scramble = 1'b1;
          held++;
          if (held >= hold_len) begin
            Read_Ready   = 1'b1;
            mem_scramble = 1'b0;
          end
        end
        if (Read_Ready) begin
          if (RLAST) done = 1;
          beat++;
          held = 0;
        end
      end
      @(negedge clk);
    end
    timed_out = !done;
    ar_after  = ARREADY;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ARREADY, Mem_Rd_En, Valid_Data_R, RLAST} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/rden/valid/last=%b required 0000",
               {ARREADY, Mem_Rd_En, Valid_Data_R, RLAST});
    end
    n_checks++;
    if ({Mem_Addr, Read_Data, R_ID_OUT} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h id=%h required 0", Mem_Addr, Read_Data, R_ID_OUT);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required %0d", state_dbg, IDLE);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_arready: got %b required 1", ARREADY);
    end
  endtask

  task automatic test_incr;
    logic [31:0] ea[4];
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run_burst(6'h01, 32'h100, 8'd3, 3'd2, BURST_INCR, -1, 0);
    n_checks++;
    if (timed_out || obs_addr.size() != 4 || obs_data.size() != 4) begin
      n_fail++;
      $display("FAIL incr_count: addrs=%0d beats=%0d timeout=%0b required 4/4/0",
               obs_addr.size(), obs_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_addr[i] !== ea[i]) begin
          n_fail++;
          $display("FAIL incr_addr[%0d]: got %h required %h", i, obs_addr[i], ea[i]);
        end
        n_checks++;
        if (obs_data[i] !== mem_word(ea[i])) begin
          n_fail++;
          $display("FAIL incr_data[%0d]: got %h required %h", i, obs_data[i], mem_word(ea[i]));
        end
        n_checks++;
        if (obs_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL incr_rlast[%0d]: got %b required %b", i, obs_last[i], (i == 3));
        end
      end
    end
    n_checks++;
    if (busy_cycles != 8) begin
      n_fail++;
      $display("FAIL incr_cycles: got %0d required 8", busy_cycles);
    end
    n_checks++;
    if (ar_after !== 1'b1 || ar_wait != 0) begin
      n_fail++;
      $display("FAIL incr_arready: after=%b wait=%0d required 1/0", ar_after, ar_wait);
    end
  endtask

  task automatic test_addr_seq(input string name, input logic [31:0] start,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [5:0] id,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ea[4];
    ea = '{e0, e1, e2, e3};
    run_burst(id, start, len, size, burst, -1, 0);
    n_checks++;
    if (timed_out || obs_addr.size() != int'(len) + 1 || obs_id.size() != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s_count: addrs=%0d beats=%0d timeout=%0b required %0d",
               name, obs_addr.size(), obs_id.size(), timed_out, int'(len) + 1);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        n_checks++;
        if (obs_addr[i] !== ea[i] || obs_data[i] !== mem_word(ea[i])) begin
          n_fail++;
          $display("FAIL %s_addr[%0d]: addr=%h data=%h required %h/%h",
                   name, i, obs_addr[i], obs_data[i], ea[i], mem_word(ea[i]));
        end
        n_checks++;
        if (obs_id[i] !== id || obs_last[i] !== (i == int'(len))) begin
          n_fail++;
          $display("FAIL %s_id_last[%0d]: id=%h last=%b required %h/%b",
                   name, i, obs_id[i], obs_last[i], id, (i == int'(len)));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ea[4];
    ea = '{32'h200, 32'h204, 32'h208, 32'h20C};
    run_burst(6'h15, 32'h200, 8'd3, 3'd2, BURST_INCR, 1, 3);
    n_checks++;
    if (timed_out || hold_data.size() != 3 || obs_addr.size() != 4) begin
      n_fail++;
      $display("FAIL hold_count: held=%0d addrs=%0d timeout=%0b required 3/4/0",
               hold_data.size(), obs_addr.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (hold_data[i] !== mem_word(32'h204)) begin
          n_fail++;
          $display("FAIL hold_data[%0d]: got %h required %h", i, hold_data[i], mem_word(32'h204));
        end
        n_checks++;
        if ({hold_valid[i], hold_last[i], hold_rden[i]} !== 3'b100) begin
          n_fail++;
          $display("FAIL hold_ctrl[%0d]: valid/last/rden=%b required 100",
                   i, {hold_valid[i], hold_last[i], hold_rden[i]});
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_addr[i] !== ea[i] || obs_data[i] !== mem_word(ea[i])) begin
          n_fail++;
          $display("FAIL hold_beat[%0d]: addr=%h data=%h required %h/%h",
                   i, obs_addr[i], obs_data[i], ea[i], mem_word(ea[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int n;
    int valids;
    @(negedge clk);
    ARID = 6'h11; ARADDR = 32'h300; ARLEN = 8'd7; ARSIZE = 3'd2;
    ARBURST = BURST_INCR; ARVALID = 1'b1; Read_Ready = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    n = 0; valids = 0;
    while (n < 40) begin
      if (Valid_Data_R) valids++;
      if (valids == 2) break;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (valids != 2) begin
      n_fail++;
      $display("FAIL midrst_reach_beat2: beats seen %0d required 2", valids);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ARREADY, Mem_Rd_En, Valid_Data_R, RLAST} !== 4'b0000 ||
        {Mem_Addr, Read_Data, R_ID_OUT} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ctrl=%b addr=%h data=%h id=%h required all 0",
               {ARREADY, Mem_Rd_En, Valid_Data_R, RLAST}, Mem_Addr, Read_Data, R_ID_OUT);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    run_burst(6'h05, 32'h80, 8'd0, 3'd2, BURST_INCR, -1, 0);
    n_checks++;
    if (ar_wait != 0) begin
      n_fail++;
      $display("FAIL midrst_ar_accept: waited %0d cycles required 0", ar_wait);
    end
    n_checks++;
    if (timed_out || obs_last.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_single_beat: beats=%0d timeout=%0b required 1/0", obs_last.size(), timed_out);
    end else begin
      n_checks++;
      if (obs_last[0] !== 1'b1 || obs_addr[0] !== 32'h80 ||
          obs_data[0] !== mem_word(32'h80) || obs_id[0] !== 6'h05) begin
        n_fail++;
        $display("FAIL midrst_beat: last=%b addr=%h data=%h id=%h required 1/00000080/%h/05",
                 obs_last[0], obs_addr[0], obs_data[0], obs_id[0], mem_word(32'h80));
      end
    end
    n_checks++;
    if (busy_cycles != 2 || ar_after !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_cycles: busy=%0d arready=%b required 2/1", busy_cycles, ar_after);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARVALID = 1'b0; Read_Ready = 1'b0; mem_scramble = 1'b0;
    test_reset();
    test_incr();
    test_addr_seq("wrap", 32'h108, 8'd3, 3'd2, BURST_WRAP, 6'h07,
                  32'h108, 32'h10C, 32'h100, 32'h104);
    test_addr_seq("fixed", 32'h40, 8'd2, 3'd2, BURST_FIXED, 6'h2A,
                  32'h40, 32'h40, 32'h40, 32'h0);
    test_addr_seq("unaligned", 32'h102, 8'd1, 3'd2, BURST_INCR, 6'h03,
                  32'h102, 32'h104, 32'h0, 32'h0);
    test_addr_seq("wrap_badlen", 32'h108, 8'd2, 3'd2, BURST_WRAP, 6'h09,
                  32'h108, 32'h10C, 32'h110, 32'h0);
    test_addr_seq("size_clamp", 32'h100, 8'd1, 3'd3, BURST_INCR, 6'h0B,
                  32'h100, 32'h104, 32'h0, 32'h0);
    test_addr_seq("reserved", 32'h3F8, 8'd1, 3'd2, 2'b11, 6'h0C,
                  32'h3F8, 32'h3FC, 32'h0, 32'h0);
    test_backpressure();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
